uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with a small receive queue.
// Oversampled by a clock-per-bit divisor; frames land in the queue with error flags.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ser_rx,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_stop2,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_BITS + 2;
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 prev_q;
    logic                 rx_s;
    logic                 rx_fall;

    state_t               state_q;
    state_t               state_d;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;
    logic [DIV_WIDTH-1:0] eff_div;
    logic [DIV_WIDTH-1:0] target;
    logic [BW-1:0]        bit_q;
    logic [BW-1:0]        bit_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;
    logic                 perr_q;
    logic                 perr_d;
    logic                 ferr_q;
    logic                 ferr_d;
    logic                 pen_q;
    logic                 pen_d;
    logic                 podd_q;
    logic                 podd_d;
    logic                 stop2_q;
    logic                 stop2_d;
    logic                 tick;
    logic                 push_req;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q;
    logic [AW-1:0]        rptr_q;
    logic [LW-1:0]        level_q;
    logic                 full;
    logic                 pop_ok;
    logic                 push_ok;
    logic [EW-1:0]        head;
    logic                 overrun_q;

    // Two-flop synchronizer plus a history flop for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= ser_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rx_s    = sync2_q;
    // A held-low line gives no new 1->0 edge, so a break cannot re-trigger.
    assign rx_fall = prev_q & ~rx_s;
    assign eff_div = (cfg_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : cfg_div;
    assign target  = (state_q == START) ? (div_q >> 1) : div_q;
    assign tick    = (cnt_q == target);

    // Receiver state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            stop2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            stop2_q <= stop2_d;
        end
    end

    // Next-state logic: count cycles since the start edge and sample mid-bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        pen_d    = pen_q;
        podd_d   = podd_q;
        stop2_d  = stop2_q;
        push_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d = START;
                    cnt_d   = DIV_WIDTH'(1);
                    div_d   = eff_div;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    pen_d   = cfg_parity_en;
                    podd_d  = cfg_parity_odd;
                    stop2_d = cfg_stop2;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    cnt_d   = DIV_WIDTH'(1);
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d   = DIV_WIDTH'(1);
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        state_d = pen_q ? PARITY : STOP1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d   = DIV_WIDTH'(1);
                    perr_d  = rx_s ^ (^shreg_q) ^ podd_q;
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (!tick) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d  = DIV_WIDTH'(1);
                    ferr_d = ~rx_s;
                    if (stop2_q) begin
                        state_d = STOP2;
                    end else begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            STOP2: begin
                if (!tick) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d    = DIV_WIDTH'(1);
                    ferr_d   = ferr_q | ~rx_s;
                    push_req = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign rd_valid = (level_q != '0);
    assign pop_ok  = rd_valid & rd_ready;
    assign push_ok = push_req & (~full | pop_ok);

    // Queue storage; cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wptr_q] <= {shreg_q, perr_q, ferr_d};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky overrun; a new drop beats a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (push_req && full && !pop_ok) begin
            overrun_q <= 1'b1;
        end else if (clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign head    = mem[rptr_q];
    assign rd_data = head[EW-1:2];
    assign rd_perr = head[1];
    assign rd_ferr = head[0];
    assign overrun = overrun_q;
    assign level   = level_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at D=106 with a 4-entry queue.
// Frames are driven bit-by-bit; every check is an immediate assertion.
module tb_uart_rx_fifo;

    localparam int D = 106;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ser_rx = 1'b1;
    logic [15:0] cfg_div = 16'(D);
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        cfg_stop2 = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_perr;
    logic        rd_ferr;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        overrun;
    logic        clr_overrun = 1'b0;
    logic        busy;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (4),
        .DIV_WIDTH  (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ser_rx         (ser_rx),
        .cfg_div        (cfg_div),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rd_data        (rd_data),
        .rd_perr        (rd_perr),
        .rd_ferr        (rd_ferr),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .overrun        (overrun),
        .clr_overrun    (clr_overrun),
        .busy           (busy),
        .level          (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        ser_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit pen, input logic pbit,
                        input logic s1, input bit s2en, input logic s2);
        hold(1'b0, D);
        for (int i = 0; i < 8; i++) hold(d[i], D);
        if (pen) hold(pbit, D);
        hold(s1, D);
        if (s2en) hold(s2, D);
        hold(1'b1, 2 * D);
    endtask

    task automatic pop(input string tag, input logic [7:0] d,
                       input logic pe, input logic fe);
        check({tag, "_valid"}, 16'(rd_valid), 16'd1);
        check({tag, "_data"}, 16'(rd_data), 16'(d));
        check({tag, "_perr"}, 16'(rd_perr), 16'(pe));
        check({tag, "_ferr"}, 16'(rd_ferr), 16'(fe));
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
    endtask

    function automatic logic fbit(input logic [7:0] d, input int c);
        int k;
        k = c / D;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        return 1'b1;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", 16'(level), 16'd0);
        check("rst_valid", 16'(rd_valid), 16'd0);
        check("rst_overrun", 16'(overrun), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_data", 16'(rd_data), 16'd0);
        check("rst_perr", 16'(rd_perr), 16'd0);
        check("rst_ferr", 16'(rd_ferr), 16'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 0x41; stop sampled at cycle 1007 after detect (edge 3).
        for (int c = 0; c < 12 * D; c++) begin
            ser_rx = fbit(8'h41, c);
            @(posedge clk);
            #1;
            if (c == 500) check("n1_busy", 16'(busy), 16'd1);
            if (c == 1008) check("n1_valid_early", 16'(rd_valid), 16'd0);
            if (c == 1009) check("n1_valid_rise", 16'(rd_valid), 16'd1);
        end
        check("n1_level", 16'(level), 16'd1);
        check("n1_idle", 16'(busy), 16'd0);
        pop("n1", 8'h41, 1'b0, 1'b0);
        check("n1_empty", 16'(level), 16'd0);

        cfg_parity_en = 1'b1;
        send(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        send(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("e1_level", 16'(level), 16'd2);
        pop("e1_bad", 8'h03, 1'b1, 1'b0);
        pop("e1_good", 8'h03, 1'b0, 1'b0);
        cfg_parity_odd = 1'b1;
        send(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        pop("o1_good", 8'h03, 1'b0, 1'b0);
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;

        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pop("ferr", 8'h55, 1'b0, 1'b1);
        cfg_stop2 = 1'b1;
        send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        pop("stop2", 8'h3C, 1'b0, 1'b1);
        cfg_stop2 = 1'b0;

        hold(1'b0, 20 * D);
        hold(1'b1, 3 * D);
        check("brk_level", 16'(level), 16'd1);
        pop("brk", 8'h00, 1'b0, 1'b1);
        check("brk_empty", 16'(level), 16'd0);

        hold(1'b0, 20);
        check("glitch_busy", 16'(busy), 16'd1);
        hold(1'b1, 200);
        check("glitch_idle", 16'(busy), 16'd0);
        check("glitch_level", 16'(level), 16'd0);

        send(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("ov_pre", 16'(overrun), 16'd0);
        send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("ov_level", 16'(level), 16'd4);
        check("ov_set", 16'(overrun), 16'd1);
        pop("ov0", 8'h11, 1'b0, 1'b0);
        pop("ov1", 8'h22, 1'b0, 1'b0);
        pop("ov2", 8'h33, 1'b0, 1'b0);
        pop("ov3", 8'h44, 1'b0, 1'b0);
        check("ov_empty", 16'(rd_valid), 16'd0);
        check("ov_sticky", 16'(overrun), 16'd1);
        clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        clr_overrun = 1'b0;
        check("ov_clr", 16'(overrun), 16'd0);

        send(8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("mr_level_pre", 16'(level), 16'd1);
        hold(1'b0, D);
        hold(1'b0, D);
        hold(1'b1, D);
        hold(1'b0, D);
        ser_rx = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("mr_busy_pre", 16'(busy), 16'd1);
        reset = 1'b1;
        #1;
        check("mr_busy", 16'(busy), 16'd0);
        check("mr_level", 16'(level), 16'd0);
        check("mr_valid", 16'(rd_valid), 16'd0);
        check("mr_data", 16'(rd_data), 16'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        hold(1'b1, 3 * D);
        check("mr_no_push", 16'(level), 16'd0);
        send(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        pop("mr_5a", 8'h5A, 1'b0, 1'b0);
        check("mr_final", 16'(level), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
